// File: rtl/audipus_pkg.sv
// Shared constants and state encoding for the SPI register bank.
// Default sizes match the original 8-out/4-in register interface.
package audipus_pkg;

   localparam int DEF_NUM_OUT_REGS = 8;
   localparam int DEF_NUM_IN_REGS  = 4;
   localparam int DEF_DATA_W       = 8;
   localparam int DEF_ADDR_W       = 7;

   // The read/write flag sits just above the address field of the command word.
   function automatic int rd_bit_pos(input int addr_w);
      return addr_w;
   endfunction

   localparam int SPI_RD_BIT = rd_bit_pos(DEF_ADDR_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      WR   = 2'd2,
      RD   = 2'd3
   } spi_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the SPI pins into clk and detects spi_clk and chip-select edges.
// CS resets to "asserted" so a frame already running when reset releases is never seen as new.
module spi_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic cs_n,
   input  logic sclk,
   input  logic mosi,
   output logic cs_n_s,
   output logic cs_fall,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic mosi_s
);

   logic [SYNC_STAGES-1:0] cs_q;
   logic [SYNC_STAGES-1:0] sclk_q;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   cs_d;
   logic                   sclk_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_q   <= '0;
         sclk_q <= '0;
         mosi_q <= '0;
         cs_d   <= 1'b0;
         sclk_d <= 1'b0;
      end else begin
         cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
         sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
         cs_d   <= cs_q[SYNC_STAGES-1];
         sclk_d <= sclk_q[SYNC_STAGES-1];
      end
   end

   assign cs_n_s    = cs_q[SYNC_STAGES-1];
   assign cs_fall   = cs_d & ~cs_n_s;
   assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
   assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
   assign mosi_s    = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_bank.sv
// Mode-0 SPI slave register bank: command word, then burst data bytes with address auto-increment.
// Writable registers read back; read-only inputs are snapshotted into the shifter at load time.
//
// state | meaning
// IDLE  | waiting for a chip-select falling edge
// CMD   | shifting in the R/W bit and address
// WR    | shifting in data bytes, committing each on its last bit
// RD    | shifting out data bytes, loading the next one on each byte's last rise
module spi_reg_bank
   import audipus_pkg::*;
#(
   parameter int NUM_OUT_REGS = DEF_NUM_OUT_REGS,
   parameter int NUM_IN_REGS  = DEF_NUM_IN_REGS,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           spi_cs_n,
   input  logic                           spi_clk,
   input  logic                           spi_mosi,
   output logic                           spi_miso,
   output logic                           miso_oe,
   input  logic [NUM_IN_REGS*DATA_W-1:0]  in_regs,
   output logic [NUM_OUT_REGS*DATA_W-1:0] out_regs,
   output logic                           wr_strobe,
   output logic [ADDR_W-1:0]              wr_addr,
   output logic                           rd_strobe,
   output logic [ADDR_W-1:0]              rd_addr,
   output logic                           addr_err,
   output logic                           frame_err
);

   localparam int CMD_W  = 1 + ADDR_W;
   localparam int MAXB   = (CMD_W > DATA_W) ? CMD_W : DATA_W;
   localparam int SH_W   = MAXB - 1;
   localparam int CNT_W  = $clog2(MAXB);
   localparam int TOTAL  = NUM_OUT_REGS + NUM_IN_REGS;
   localparam int RD_BIT = rd_bit_pos(ADDR_W);

   localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [ADDR_W-1:0] OUT_LIM   = ADDR_W'(NUM_OUT_REGS);
   localparam logic [ADDR_W-1:0] MAP_LAST  = ADDR_W'(TOTAL - 1);

   logic cs_n_s, cs_fall, sclk_rise, sclk_fall, mosi_s;

   spi_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .cs_n      (spi_cs_n),
      .sclk      (spi_clk),
      .mosi      (spi_mosi),
      .cs_n_s    (cs_n_s),
      .cs_fall   (cs_fall),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .mosi_s    (mosi_s)
   );

   spi_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [SH_W-1:0]   shift_in, shift_in_nxt;
   logic [DATA_W-1:0] shift_out, shift_out_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [DATA_W-1:0] regs [NUM_OUT_REGS];
   logic [DATA_W-1:0] regs_nxt [NUM_OUT_REGS];

   logic              miso_nxt, wr_strobe_nxt, rd_strobe_nxt, addr_err_nxt, frame_err_nxt;
   logic [ADDR_W-1:0] wr_addr_nxt, rd_addr_nxt;

   logic [CMD_W-1:0]  cmd_word;
   logic [DATA_W-1:0] data_word;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] load_addr;
   logic              load_mapped;
   logic [DATA_W-1:0] rd_byte;

   assign cmd_word  = {shift_in[CMD_W-2:0], mosi_s};
   assign data_word = {shift_in[DATA_W-2:0], mosi_s};

   // Mapped addresses wrap inside the bank; unmapped ones run on to the top of the address space.
   always_comb begin
      addr_inc = addr + 1'b1;
      if (addr == MAP_LAST) begin
         addr_inc = '0;
      end
   end

   assign load_addr   = (state == CMD) ? cmd_word[ADDR_W-1:0] : addr_inc;
   assign load_mapped = (load_addr <= MAP_LAST);

   always_comb begin
      rd_byte = '0;
      for (int k = 0; k < NUM_OUT_REGS; k++) begin
         if (load_addr == ADDR_W'(k)) begin
            rd_byte = regs[k];
         end
      end
      for (int k = 0; k < NUM_IN_REGS; k++) begin
         if (load_addr == ADDR_W'(NUM_OUT_REGS + k)) begin
            rd_byte = in_regs[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      shift_in_nxt  = shift_in;
      shift_out_nxt = shift_out;
      addr_nxt      = addr;
      miso_nxt      = spi_miso;
      wr_strobe_nxt = 1'b0;
      rd_strobe_nxt = 1'b0;
      addr_err_nxt  = 1'b0;
      frame_err_nxt = 1'b0;
      wr_addr_nxt   = wr_addr;
      rd_addr_nxt   = rd_addr;
      for (int k = 0; k < NUM_OUT_REGS; k++) begin
         regs_nxt[k] = regs[k];
      end

      // Chip-select release takes priority over any spi_clk edge seen in the same cycle.
      if (state != IDLE && cs_n_s) begin
         state_nxt     = IDLE;
         cnt_nxt       = '0;
         miso_nxt      = 1'b0;
         frame_err_nxt = (cnt != '0);
      end else begin
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state_nxt = CMD;
                  cnt_nxt   = '0;
                  miso_nxt  = 1'b0;
               end
            end
            CMD: begin
               if (sclk_rise) begin
                  shift_in_nxt = {shift_in[SH_W-2:0], mosi_s};
                  if (cnt == CMD_LAST) begin
                     cnt_nxt  = '0;
                     addr_nxt = cmd_word[ADDR_W-1:0];
                     if (cmd_word[RD_BIT]) begin
                        state_nxt     = RD;
                        miso_nxt      = rd_byte[DATA_W-1];
                        shift_out_nxt = rd_byte << 1;
                        rd_strobe_nxt = 1'b1;
                        rd_addr_nxt   = load_addr;
                        addr_err_nxt  = ~load_mapped;
                     end else begin
                        state_nxt = WR;
                     end
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
            WR: begin
               if (sclk_rise) begin
                  shift_in_nxt = {shift_in[SH_W-2:0], mosi_s};
                  if (cnt == DATA_LAST) begin
                     cnt_nxt  = '0;
                     addr_nxt = addr_inc;
                     if (addr < OUT_LIM) begin
                        wr_strobe_nxt = 1'b1;
                        wr_addr_nxt   = addr;
                        for (int k = 0; k < NUM_OUT_REGS; k++) begin
                           if (addr == ADDR_W'(k)) begin
                              regs_nxt[k] = data_word;
                           end
                        end
                     end else begin
                        addr_err_nxt = 1'b1;
                     end
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
            RD: begin
               if (sclk_rise) begin
                  if (cnt == DATA_LAST) begin
                     cnt_nxt       = '0;
                     addr_nxt      = addr_inc;
                     miso_nxt      = rd_byte[DATA_W-1];
                     shift_out_nxt = rd_byte << 1;
                     rd_strobe_nxt = 1'b1;
                     rd_addr_nxt   = load_addr;
                     addr_err_nxt  = ~load_mapped;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end else if (sclk_fall && cnt != '0) begin
                  // The fall right after a load keeps the MSB up for the master's next rise.
                  miso_nxt      = shift_out[DATA_W-1];
                  shift_out_nxt = shift_out << 1;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         shift_in  <= '0;
         shift_out <= '0;
         addr      <= '0;
         spi_miso  <= 1'b0;
         wr_strobe <= 1'b0;
         rd_strobe <= 1'b0;
         addr_err  <= 1'b0;
         frame_err <= 1'b0;
         wr_addr   <= '0;
         rd_addr   <= '0;
         for (int k = 0; k < NUM_OUT_REGS; k++) begin
            regs[k] <= '0;
         end
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         shift_in  <= shift_in_nxt;
         shift_out <= shift_out_nxt;
         addr      <= addr_nxt;
         spi_miso  <= miso_nxt;
         wr_strobe <= wr_strobe_nxt;
         rd_strobe <= rd_strobe_nxt;
         addr_err  <= addr_err_nxt;
         frame_err <= frame_err_nxt;
         wr_addr   <= wr_addr_nxt;
         rd_addr   <= rd_addr_nxt;
         for (int k = 0; k < NUM_OUT_REGS; k++) begin
            regs[k] <= regs_nxt[k];
         end
      end
   end

   assign miso_oe = (state != IDLE);

   for (genvar k = 0; k < NUM_OUT_REGS; k++) begin : g_pack
      assign out_regs[k*DATA_W +: DATA_W] = regs[k];
   end

endmodule
